// File: rtl/writeback_stage_if.sv
// Writeback stage bus: MEM-slot inputs, stall/flush controls and
// register-file write outputs. Optional bypass ports under WB_BYPASS_EN.
interface writeback_stage_if #(
  parameter int CNT_W = 64
);
  logic             memValid;
  logic             memRegWrite;
  logic [4:0]       memRd;
  logic [1:0]       memResultSel;
  logic [31:0]      memAluResult;
  logic [31:0]      memPcPlus4;
  logic [2:0]       memFunct3;
  logic [31:0]      memLoadData;
  logic             stall;
  logic             flush;
  logic [4:0]       rd;
  logic             writeEnable;
  logic [31:0]      writeData;
  logic             wbValid;
  logic             misalignedLoad;
  logic [CNT_W-1:0] instret;
`ifdef WB_BYPASS_EN
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [31:0]      rfData1;
  logic [31:0]      rfData2;
  logic [31:0]      fwdData1;
  logic [31:0]      fwdData2;
`endif

  modport master (
    output memValid, memRegWrite, memRd, memResultSel,
    output memAluResult, memPcPlus4, memFunct3, memLoadData,
    output stall, flush,
`ifdef WB_BYPASS_EN
    output rs1, rs2, rfData1, rfData2,
    input  fwdData1, fwdData2,
`endif
    input  rd, writeEnable, writeData, wbValid,
    input  misalignedLoad, instret
  );

  modport slave (
    input  memValid, memRegWrite, memRd, memResultSel,
    input  memAluResult, memPcPlus4, memFunct3, memLoadData,
    input  stall, flush,
`ifdef WB_BYPASS_EN
    input  rs1, rs2, rfData1, rfData2,
    output fwdData1, fwdData2,
`endif
    output rd, writeEnable, writeData, wbValid,
    output misalignedLoad, instret
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: one registered slot, load extract, retire counter.
// Optional macro WB_BYPASS_EN adds write-data forwarding to rs1/rs2.
module writeback_stage #(
  parameter int CNT_W = 64
) (
  input logic               clk,
  input logic               rst,
  writeback_stage_if.slave  wb
);

  logic             r_valid;
  logic             r_regWrite;
  logic [4:0]       r_rd;
  logic [31:0]      r_data;
  logic             r_mis;
  logic [CNT_W-1:0] r_instret;

  logic [1:0]  w_lane;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic        w_isLoad;
  logic        w_isHalf;
  logic        w_isByte;
  logic        w_mis;
  logic [31:0] w_result;
  logic        w_retire;

  assign w_lane   = wb.memAluResult[1:0];
  assign w_half   = w_lane[1] ? wb.memLoadData[31:16]
                              : wb.memLoadData[15:0];
  assign w_isLoad = (wb.memResultSel == 2'b01);
  assign w_isHalf = (wb.memFunct3 == 3'b001) ||
                    (wb.memFunct3 == 3'b101);
  assign w_isByte = (wb.memFunct3 == 3'b000) ||
                    (wb.memFunct3 == 3'b100);

  // Byte lane select and sign/zero extension; unknown funct3 acts as LW.
  always_comb begin
    w_byte = wb.memLoadData[7:0];
    unique case (w_lane)
      2'd0: w_byte = wb.memLoadData[7:0];
      2'd1: w_byte = wb.memLoadData[15:8];
      2'd2: w_byte = wb.memLoadData[23:16];
      2'd3: w_byte = wb.memLoadData[31:24];
    endcase
    w_load = wb.memLoadData;
    case (wb.memFunct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = wb.memLoadData;
    endcase
  end

  // Misalignment: halves need addr[0]=0, words need addr[1:0]=0.
  always_comb begin
    w_mis = 1'b0;
    if (w_isLoad && !w_isByte) begin
      if (w_isHalf) w_mis = w_lane[0];
      else          w_mis = (w_lane != 2'b00);
    end
  end

  // Result source mux; encoding 11 falls back to the ALU result.
  always_comb begin
    unique case (wb.memResultSel)
      2'b01:   w_result = w_load;
      2'b10:   w_result = wb.memPcPlus4;
      default: w_result = wb.memAluResult;
    endcase
  end

  // A held instruction leaves the slot when not stalled or when flushed.
  assign w_retire = r_valid && (!wb.stall || wb.flush);

  // Slot capture/hold/flush plus retire counting, sync active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_regWrite <= 1'b0;
      r_rd       <= 5'd0;
      r_data     <= 32'd0;
      r_mis      <= 1'b0;
      r_instret  <= '0;
    end else begin
      if (w_retire) r_instret <= r_instret + 1'b1;
      if (wb.flush) begin
        r_valid <= 1'b0;
      end else if (!wb.stall) begin
        r_valid    <= wb.memValid;
        r_regWrite <= wb.memRegWrite;
        r_rd       <= wb.memRd;
        r_data     <= w_result;
        r_mis      <= w_mis;
      end
    end
  end

  assign wb.wbValid        = r_valid;
  assign wb.rd             = r_rd;
  assign wb.writeData      = r_data;
  assign wb.misalignedLoad = r_valid & r_mis;
  assign wb.instret        = r_instret;
  assign wb.writeEnable    = r_valid & r_regWrite &
                             (r_rd != 5'd0) & ~r_mis;

`ifdef WB_BYPASS_EN
  assign wb.fwdData1 = (wb.writeEnable && wb.rd == wb.rs1)
                       ? r_data : wb.rfData1;
  assign wb.fwdData2 = (wb.writeEnable && wb.rd == wb.rs2)
                       ? r_data : wb.rfData2;
`endif

endmodule
